monte_move_scheduler: RTL and testbench

Sequencer for the four per-direction Monte-Carlo statistics engines (restricted directions 0–3) behind the UART virtual bus. On a start command it:
- latches a seed and drives the engines' shared reset and seed;
- lets them run for a programmed number of cycles, then snapshots their total move counts;
- compares the snapshots sequentially and reports the best move direction.

It replaces direct bus-driven release of the engine reset, so a host issues one command per decision and polls `busy`/`done`.

---
 rtl/monte_move_scheduler.sv | 159 +++++++++++++++
 tb/tb_monte_move_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/monte_move_scheduler.sv
// rtl/monte_move_scheduler.sv - sequences the four direction engines through clear, run, snapshot and best-move compare
module monte_move_scheduler #(
    parameter int CLR_CYCLES = 4,
    parameter int RUN_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       seed_in,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [127:0]     eng_total,
    output logic             eng_rst,
    output logic [7:0]       eng_seed,
    output logic             busy,
    output logic             done,
    output logic             seed_err,
    output logic [1:0]       best_dir,
    output logic [31:0]      best_total,
    output logic             no_move
);

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_SNAP, S_CMP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [7:0]          seed_q, seed_d;
    logic                seed_err_q, seed_err_d;
    logic [3:0][31:0]    snap_q, snap_d;
    logic [1:0]          cmp_idx_q, cmp_idx_d;
    logic [31:0]         max_q, max_d;
    logic [1:0]          idx_q, idx_d;
    logic [1:0]          best_dir_q, best_dir_d;
    logic [31:0]         best_total_q, best_total_d;
    logic                no_move_q, no_move_d;

    logic [31:0]         cur_total;
    logic                cur_gt;
    logic [31:0]         new_max;
    logic [1:0]          new_idx;

    // Strict greater-than keeps the lower index on ties.
    assign cur_total = snap_q[cmp_idx_q];
    assign cur_gt    = cur_total > max_q;
    assign new_max   = cur_gt ? cur_total : max_q;
    assign new_idx   = cur_gt ? cmp_idx_q : idx_q;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        run_cnt_d    = run_cnt_q;
        seed_d       = seed_q;
        seed_err_d   = 1'b0;
        snap_d       = snap_q;
        cmp_idx_d    = cmp_idx_q;
        max_d        = max_q;
        idx_d        = idx_q;
        best_dir_d   = best_dir_q;
        best_total_d = best_total_q;
        no_move_d    = no_move_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (seed_in != 8'd0) begin
                        seed_d    = seed_in;
                        run_cnt_d = (run_cycles == '0) ? RUN_W'(1) : run_cycles;
                        clr_cnt_d = CLR_W'(CLR_CYCLES);
                        state_d   = S_CLEAR;
                    end else begin
                        seed_err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q != '0) clr_cnt_d = clr_cnt_q - CLR_W'(1);
                if (clr_cnt_q <= CLR_W'(1)) state_d = S_RUN;
            end
            S_RUN: begin
                if (run_cnt_q != '0) run_cnt_d = run_cnt_q - RUN_W'(1);
                if (run_cnt_q <= RUN_W'(1)) state_d = S_SNAP;
            end
            S_SNAP: begin
                snap_d    = eng_total;
                cmp_idx_d = 2'd0;
                max_d     = 32'd0;
                idx_d     = 2'd0;
                state_d   = S_CMP;
            end
            S_CMP: begin
                max_d     = new_max;
                idx_d     = new_idx;
                cmp_idx_d = cmp_idx_q + 2'd1;
                if (cmp_idx_q == 2'd3) begin
                    best_dir_d   = new_idx;
                    best_total_d = new_max;
                    no_move_d    = (new_max == 32'd0);
                    state_d      = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // An abort landing on the last compare must not publish partial results.
        if (abort && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            best_dir_d   = best_dir_q;
            best_total_d = best_total_q;
            no_move_d    = no_move_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            run_cnt_q    <= '0;
            seed_q       <= 8'd0;
            seed_err_q   <= 1'b0;
            snap_q       <= '0;
            cmp_idx_q    <= 2'd0;
            max_q        <= 32'd0;
            idx_q        <= 2'd0;
            best_dir_q   <= 2'd0;
            best_total_q <= 32'd0;
            no_move_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            run_cnt_q    <= run_cnt_d;
            seed_q       <= seed_d;
            seed_err_q   <= seed_err_d;
            snap_q       <= snap_d;
            cmp_idx_q    <= cmp_idx_d;
            max_q        <= max_d;
            idx_q        <= idx_d;
            best_dir_q   <= best_dir_d;
            best_total_q <= best_total_d;
            no_move_q    <= no_move_d;
        end
    end

    // Engines only leave reset while running and during the snapshot cycle.
    assign eng_rst    = !(state_q == S_RUN || state_q == S_SNAP);
    assign eng_seed   = seed_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign seed_err   = seed_err_q;
    assign best_dir   = best_dir_q;
    assign best_total = best_total_q;
    assign no_move    = no_move_q;

endmodule

// File: tb/tb_monte_move_scheduler.sv
// tb/tb_monte_move_scheduler.sv - scoreboard bench for monte_move_scheduler
module tb_monte_move_scheduler;

    localparam int CLR = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [7:0]   seed_in = 8'd0;
    logic [23:0]  run_cycles = 24'd0;
    logic [127:0] eng_total = '0;
    logic         eng_rst, busy, done, seed_err, no_move;
    logic [7:0]   eng_seed;
    logic [1:0]   best_dir;
    logic [31:0]  best_total;

    monte_move_scheduler #(.CLR_CYCLES(CLR), .RUN_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .seed_in(seed_in), .run_cycles(run_cycles), .eng_total(eng_total),
        .eng_rst(eng_rst), .eng_seed(eng_seed), .busy(busy), .done(done),
        .seed_err(seed_err), .best_dir(best_dir), .best_total(best_total),
        .no_move(no_move)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dir;
        logic [31:0] tot;
        logic        nm;
        logic [7:0]  seed;
        int          cyc;
        int          low;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Monitor: pops an expectation on every done pulse.
    initial begin
        int   low_cnt;
        exp_t e;
        low_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst || !busy) low_cnt = 0;
            else if (!eng_rst) low_cnt++;
            if (rst && done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("best_dir", best_dir, e.dir);
                    chk("best_total", best_total, e.tot);
                    chk("no_move", no_move, e.nm);
                    chk("eng_seed", eng_seed, e.seed);
                    chk("eng_rst_low_cycles", low_cnt, e.low);
                end
            end
        end
    end

    // Issue a start; returns with the first negedge after the accepting edge.
    task automatic issue(input logic [7:0] sd, input logic [23:0] rc, input logic [127:0] tot);
        start      = 1'b1;
        seed_in    = sd;
        run_cycles = rc;
        eng_total  = tot;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input logic [7:0] sd, input logic [23:0] rc, input logic [127:0] tot,
                       input logic [1:0] dir, input logic [31:0] best, input logic nm,
                       input bit hold);
        exp_t e;
        int   r;
        bit   seen;
        r = (rc == 0) ? 1 : int'(rc);
        issue(sd, rc, tot);
        if (!hold) start = 1'b0;
        e.dir = dir; e.tot = best; e.nm = nm; e.seed = sd;
        e.cyc = cyc + CLR + r + 5; e.low = r + 1;
        exp_q.push_back(e);
        chk("busy_after_start", busy, 1);
        chk("eng_rst_in_clear", eng_rst, 1);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_cleared", done, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_eng_rst", eng_rst, 1);
        chk("rst_eng_seed", eng_seed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_seed_err", seed_err, 0);
        chk("rst_best_dir", best_dir, 0);
        chk("rst_best_total", best_total, 0);
        chk("rst_no_move", no_move, 0);
        rst = 1'b1;
        @(negedge clk);

        // Nominal: tie between dir1 and dir2 resolves low
        run(8'h5A, 24'd10, {32'd400, 32'd900, 32'd900, 32'd100}, 2'd1, 32'd900, 1'b0, 0);
        // Game over
        run(8'h33, 24'd3, 128'd0, 2'd0, 32'd0, 1'b1, 0);

        // Seed error
        start = 1'b1; seed_in = 8'h00;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("seed_err_pulse", seed_err, 1);
        chk("seed_err_busy", busy, 0);
        chk("seed_err_seed_kept", eng_seed, 8'h33);
        @(negedge clk);
        chk("seed_err_single", seed_err, 0);

        // Abort in cycle 5 of a 10-cycle run
        issue(8'h77, 24'd10, {32'd1, 32'd2, 32'd3, 32'd4});
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_pre_running", eng_rst, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_eng_rst", eng_rst, 1);
        chk("abort_keep_dir", best_dir, 0);
        chk("abort_keep_total", best_total, 0);
        chk("abort_keep_no_move", no_move, 1);
        run(8'h11, 24'd2, {32'd10, 32'd30, 32'd5, 32'd20}, 2'd2, 32'd30, 1'b0, 0);

        // run_cycles 0 acts as 1
        run(8'h01, 24'd0, {32'd0, 32'd0, 32'd7, 32'd0}, 2'd1, 32'd7, 1'b0, 0);
        // start held high while busy
        run(8'h22, 24'd6, {32'd8, 32'd9, 32'd1, 32'd2}, 2'd2, 32'd9, 1'b0, 1);

        // start with abort in IDLE
        start = 1'b1; abort = 1'b1; seed_in = 8'h44;
        @(posedge clk); @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_seed", eng_seed, 8'h22);
        chk("start_abort_no_err", seed_err, 0);

        // Full-scale total on dir3
        run(8'hC3, 24'd4, {32'hFFFFFFFF, 32'd5, 32'd6, 32'd7}, 2'd3, 32'hFFFFFFFF, 1'b0, 0);

        // Asynchronous reset in the middle of CMP
        issue(8'h42, 24'd1, {32'd1, 32'd1, 32'd1, 32'd9});
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_reset_in_cmp", eng_rst, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_eng_rst", eng_rst, 1);
        chk("arst_eng_seed", eng_seed, 0);
        chk("arst_best_total", best_total, 0);
        chk("arst_best_dir", best_dir, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // All-equal totals after reset
        run(8'h9C, 24'd5, {32'd3, 32'd3, 32'd3, 32'd3}, 2'd0, 32'd3, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("pending_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
